pitch_controller: RTL



---
 rtl/pitch_pkg.sv | 16 +
 rtl/pitch_controller_echo_timer.sv | 58 +++++
 rtl/pitch_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pitch_pkg.sv
// Shared types and widths for the theremin pitch-sensing block.
package pitch_pkg;

    localparam int TONE_W = 16;
    localparam int FREQ_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        UPDATE,
        HOLD
    } state_t;

endpackage

// File: rtl/pitch_controller_echo_timer.sv
// echo_timer: prescaled, saturating echo-width counter with an echo-high timeout flag.
module echo_timer
    import pitch_pkg::*;
#(
    parameter int unsigned DIV_CYC     = 100,
    parameter int unsigned TIMEOUT_CYC = 3000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              run_i,
    output logic [TONE_W-1:0] width_o,
    output logic              timeout_o
);

    logic [31:0]       pre_q, pre_d, pre_base;
    logic [31:0]       hi_q, hi_d, hi_base;
    logic [TONE_W-1:0] width_q, width_d, width_base;

    // A start clears the count and also counts the cycle it arrives in.
    always_comb begin
        pre_base   = start_i ? '0 : pre_q;
        hi_base    = start_i ? '0 : hi_q;
        width_base = start_i ? '0 : width_q;
        pre_d      = pre_base;
        hi_d       = hi_base;
        width_d    = width_base;
        if (start_i || run_i) begin
            if (hi_base != TIMEOUT_CYC) begin
                hi_d = hi_base + 32'd1;
            end
            if (pre_base == DIV_CYC - 1) begin
                pre_d = '0;
                if (width_base != '1) begin
                    width_d = width_base + TONE_W'(1);
                end
            end else begin
                pre_d = pre_base + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            hi_q    <= '0;
            width_q <= '0;
        end else begin
            pre_q   <= pre_d;
            hi_q    <= hi_d;
            width_q <= width_d;
        end
    end

    assign width_o   = width_q;
    assign timeout_o = (hi_q == TIMEOUT_CYC);

endmodule

// File: rtl/pitch_controller.sv
// pitch_controller: trigger/echo sequencer producing tone code, registered frequency and mute.
// Optional macro PITCH_CTRL_AVG_EN: tone is the mean of the last four valid widths.
module pitch_controller
    import pitch_pkg::*;
#(
    parameter int unsigned TRIG_CYC    = 1000,
    parameter int unsigned DIV_CYC     = 100,
    parameter int unsigned TIMEOUT_CYC = 3000000,
    parameter int unsigned PERIOD_CYC  = 6000000,
    parameter int unsigned MISS_LIMIT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [TONE_W-1:0] tone,
    input  logic [FREQ_W-1:0] freq_in,
    output logic [FREQ_W-1:0] freq,
    output logic              freq_valid,
    output logic              mute
);

    localparam int unsigned       MISS_W   = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
`ifdef PITCH_CTRL_AVG_EN
    localparam logic [1:0]        UPD_LAST = 2'd2;
`else
    localparam logic [1:0]        UPD_LAST = 2'd1;
`endif

    state_t             state_q;
    logic               trig_q, freq_valid_q, mute_q;
    logic [TONE_W-1:0]  tone_q;
    logic [FREQ_W-1:0]  freq_q;
    logic [31:0]        cnt_q, period_q, period_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [1:0]         upd_q;
    logic               timer_start, timer_run, timer_timeout;
    logic [TONE_W-1:0]  width;

`ifdef PITCH_CTRL_AVG_EN
    logic [TONE_W-1:0]  hist_q [4];
    logic [TONE_W+1:0]  sum_q, sum_d;
    assign sum_d = sum_q + {2'b00, width} - {2'b00, hist_q[3]};
`endif

    always_comb begin
        period_d    = (period_q == 32'hFFFF_FFFF) ? period_q : period_q + 32'd1;
        miss_d      = (miss_q == MISS_MAX) ? miss_q : miss_q + MISS_W'(1);
        timer_start = (state_q == WAIT_RISE) && echo;
        timer_run   = (state_q == MEASURE) && echo && !timer_timeout;
    end

    echo_timer #(
        .DIV_CYC     (DIV_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_echo_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (timer_start),
        .run_i     (timer_run),
        .width_o   (width),
        .timeout_o (timer_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            trig_q       <= 1'b0;
            tone_q       <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            mute_q       <= 1'b1;
            cnt_q        <= '0;
            period_q     <= '0;
            miss_q       <= '0;
            upd_q        <= '0;
`ifdef PITCH_CTRL_AVG_EN
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            sum_q        <= '0;
`endif
        end else begin
            freq_valid_q <= 1'b0;
            period_q     <= period_d;
            cnt_q        <= cnt_q + 32'd1;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q  <= TRIG;
                        trig_q   <= 1'b1;
                        cnt_q    <= '0;
                        period_q <= '0;
                    end
                end
                TRIG: begin
                    if (cnt_q == TRIG_CYC - 1) begin
                        state_q <= WAIT_RISE;
                        trig_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                WAIT_RISE: begin
                    // Echo wins over the timeout on the last allowed cycle.
                    if (echo) begin
                        state_q <= MEASURE;
                    end else if (cnt_q == TIMEOUT_CYC - 1) begin
                        state_q <= HOLD;
                        miss_q  <= miss_d;
                        if (miss_d == MISS_MAX) mute_q <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!echo) begin
                        state_q <= UPDATE;
                        upd_q   <= '0;
                    end else if (timer_timeout) begin
                        state_q <= HOLD;
                        miss_q  <= miss_d;
                        if (miss_d == MISS_MAX) mute_q <= 1'b1;
                    end
                end
                UPDATE: begin
                    upd_q <= upd_q + 2'd1;
`ifdef PITCH_CTRL_AVG_EN
                    if (upd_q == 2'd0) begin
                        hist_q[0] <= width;
                        for (int i = 1; i < 4; i++) begin
                            hist_q[i] <= hist_q[i-1];
                        end
                        sum_q <= sum_d;
                    end
                    if (upd_q == 2'd1) tone_q <= sum_q[TONE_W+1:2];
`else
                    if (upd_q == 2'd0) tone_q <= width;
`endif
                    // freq_in is combinational from tone, so it is sampled a cycle after tone settles.
                    if (upd_q == UPD_LAST) begin
                        freq_q       <= freq_in;
                        freq_valid_q <= 1'b1;
                        miss_q       <= '0;
                        mute_q       <= 1'b0;
                        state_q      <= enable ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (period_q >= PERIOD_CYC - 1) begin
                        if (enable) begin
                            state_q  <= TRIG;
                            trig_q   <= 1'b1;
                            cnt_q    <= '0;
                            period_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trig       = trig_q;
    assign tone       = tone_q;
    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign mute       = mute_q;

endmodule
